// File: rtl/hera_uart_pkg.sv
// Shared types and constants for the HyperTerminal UART transmitter.
package hera_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned BAUD_115200_DIV = 417;

    // Data must be zero-extended so unused upper bits do not affect the result.
    function automatic logic calc_parity(input logic [7:0] data, input int unsigned mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Valid/ready write port feeding the buffered UART transmitter.
interface uart_tx_buffered_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );

endinterface

// File: rtl/hera_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and an occupancy count.
module hera_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_48,
    input  logic                     rst_,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rptr_q];
    assign level   = count_q;

    always_ff @(posedge clk_48) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk_48 or negedge rst_) begin
        if (!rst_) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered RS-232 transmitter: write port -> FIFO -> framed serial output on tx.
// New frames start only when the synchronised CTS allows it (if FLOW_CTRL is set).
module uart_tx_buffered
    import hera_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = BAUD_115200_DIV,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = PAR_NONE,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FLOW_CTRL  = 1
) (
    input  logic                         clk_48,
    input  logic                         rst_,
    uart_tx_buffered_if.slave            wr,
    input  logic                         cts_in,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic                 cts_meta_q, cts_s_q;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 start_ok, bit_end, last_data, last_stop, load;

    always_ff @(posedge clk_48 or negedge rst_) begin
        if (!rst_) begin
            cts_meta_q <= 1'b0;
            cts_s_q    <= 1'b0;
        end else begin
            cts_meta_q <= cts_in;
            cts_s_q    <= cts_meta_q;
        end
    end

    assign wr.wr_ready = ~fifo_full;
    assign fifo_push   = wr.wr_valid & ~fifo_full;
    assign fifo_pop    = load;

    hera_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_48 (clk_48),
        .rst_   (rst_),
        .push   (fifo_push),
        .wdata  (wr.wr_data),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    assign start_ok  = ~fifo_empty & (cts_s_q | (FLOW_CTRL == 0));
    assign bit_end   = (baud_cnt_q == CNT_W'(CLK_DIV - 1));
    assign last_data = (bit_idx_q == 3'(DATA_BITS - 1));
    assign last_stop = (bit_idx_q == 3'(STOP_BITS - 1));

    always_ff @(posedge clk_48 or negedge rst_) begin
        if (!rst_) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StStart;
                    load    = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end && last_data) begin
                    state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // Chain straight into the next start bit when data is waiting.
                if (bit_end && last_stop) begin
                    if (start_ok) begin
                        state_d = StStart;
                        load    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
            StParity: tx_d = par_q;
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        if (load) begin
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            shift_d    = fifo_rdata;
            par_d      = calc_parity(8'(fifo_rdata), PARITY);
        end else if (state_q == StIdle) begin
            baud_cnt_d = '0;
            bit_idx_d  = '0;
        end else if (!bit_end) begin
            baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end else begin
            baud_cnt_d = '0;
            if (state_q == StData) begin
                shift_d   = shift_q >> 1;
                bit_idx_d = last_data ? 3'd0 : bit_idx_q + 3'd1;
            end else if (state_q == StStop) begin
                bit_idx_d = bit_idx_q + 3'd1;
            end
        end
    end

    // tx is registered, so the line trails the FSM state by one cycle.
    always_ff @(posedge clk_48 or negedge rst_) begin
        if (!rst_) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three instances (8N1, 8O2, 8E1) at CLK_DIV=4, line
// waveforms compared cycle by cycle against frames built from the word values.
module tb_uart_tx_buffered;

    localparam int unsigned DIV   = 4;
    localparam int unsigned NDUT  = 3;
    localparam int unsigned DEPTH = 16;

    logic       clk_48 = 1'b0;
    logic       rst_;
    logic [7:0] wr_data  [NDUT];
    logic       wr_valid [NDUT];
    logic       wr_ready [NDUT];
    logic       cts      [NDUT];
    logic       tx       [NDUT];
    logic       busy     [NDUT];
    logic [4:0] level    [NDUT];

    int unsigned n_checks;
    int unsigned n_pass;

    always #5 clk_48 = ~clk_48;

    // Instance g: parity mode g (0 none, 1 odd, 2 even); instance 1 uses two stop bits.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned Stops = (g == 1) ? 2 : 1;

        uart_tx_buffered_if #(.DATA_BITS(8)) wr_if ();

        assign wr_if.wr_data  = wr_data[g];
        assign wr_if.wr_valid = wr_valid[g];
        assign wr_ready[g]    = wr_if.wr_ready;

        uart_tx_buffered #(
            .CLK_DIV    (DIV),
            .DATA_BITS  (8),
            .PARITY     (g),
            .STOP_BITS  (Stops),
            .FIFO_DEPTH (DEPTH),
            .FLOW_CTRL  (1)
        ) u_dut (
            .clk_48     (clk_48),
            .rst_       (rst_),
            .wr         (wr_if),
            .cts_in     (cts[g]),
            .tx         (tx[g]),
            .busy       (busy[g]),
            .fifo_level (level[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned stop_bits(input int idx);
        return (idx == 1) ? 2 : 1;
    endfunction

    function automatic int unsigned frame_bits(input int idx, input logic [7:0] w);
        return 1 + 8 + ((idx != 0) ? 1 : 0) + stop_bits(idx);
    endfunction

    // Expected line level for bit position pos of the frame carrying w.
    function automatic logic exp_bit(input int idx, input logic [7:0] w, input int unsigned pos);
        int unsigned ones;
        ones = $countones(w);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return w[pos-1];
        if (idx != 0 && pos == 9) return (idx == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        return 1'b1;
    endfunction

    task automatic write_word(input int idx, input logic [7:0] w);
        wr_data[idx]  = w;
        wr_valid[idx] = 1'b1;
        @(negedge clk_48);
        wr_valid[idx] = 1'b0;
    endtask

    // Waits up to max_wait cycles for the start bit, then checks every cycle of the frame.
    task automatic check_frame(input int idx, input logic [7:0] w, input int unsigned max_wait,
                               input string tag);
        int unsigned waited;
        @(negedge clk_48);
        waited = 1;
        while (tx[idx] !== 1'b0 && waited < max_wait) begin
            @(negedge clk_48);
            waited++;
        end
        if (tx[idx] !== 1'b0) begin
            check_eq({tag, " start"}, tx[idx], 0);
            return;
        end
        for (int unsigned pos = 0; pos < frame_bits(idx, w); pos++) begin
            for (int unsigned c = 0; c < DIV; c++) begin
                if (!(pos == 0 && c == 0)) @(negedge clk_48);
                check_eq(tag, tx[idx], exp_bit(idx, w, pos));
            end
        end
    endtask

    // Queue n words with CTS low, then release CTS and expect back-to-back frames.
    task automatic burst(input int idx, input int unsigned n, input logic [7:0] first);
        logic [7:0]  words [DEPTH];
        int unsigned lows;
        cts[idx] = 1'b0;
        repeat (3) @(negedge clk_48);
        for (int unsigned i = 0; i < n; i++) begin
            words[i] = (i == 0) ? first : 8'($urandom);
            write_word(idx, words[i]);
        end
        check_eq("burst level", level[idx], n);
        check_eq("burst busy", busy[idx], 1);
        if (n == DEPTH) begin
            check_eq("full ready", wr_ready[idx], 0);
            write_word(idx, 8'hA5);
            check_eq("full refused", level[idx], DEPTH);
        end
        lows = 0;
        repeat (20) begin
            @(negedge clk_48);
            if (tx[idx] !== 1'b1) lows++;
        end
        check_eq("gated tx idle", lows, 0);
        cts[idx] = 1'b1;
        check_frame(idx, words[0], 10, "burst first");
        for (int unsigned i = 1; i < n; i++) begin
            check_frame(idx, words[i], 1, "burst chained");
        end
        repeat (3) @(negedge clk_48);
        check_eq("burst drained", level[idx], 0);
        check_eq("burst not busy", busy[idx], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] wa, wb;
        int unsigned lows;
        n_checks = 0;
        n_pass   = 0;
        rst_     = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            wr_data[i]  = '0;
            wr_valid[i] = 1'b0;
            cts[i]      = 1'b1;
        end
        repeat (3) @(negedge clk_48);
        for (int i = 0; i < NDUT; i++) begin
            check_eq("reset tx", tx[i], 1);
            check_eq("reset ready", wr_ready[i], 1);
            check_eq("reset busy", busy[i], 0);
            check_eq("reset level", level[i], 0);
        end
        rst_ = 1'b1;
        repeat (4) @(negedge clk_48);

        // Single word 0x55 on 8N1: start bit due exactly two edges after the write.
        write_word(0, 8'h55);
        check_eq("lat level", level[0], 1);
        check_eq("lat busy", busy[0], 1);
        check_eq("lat tx N", tx[0], 1);
        @(negedge clk_48);
        check_eq("lat tx N+1", tx[0], 1);
        check_frame(0, 8'h55, 1, "frame 55");
        repeat (3) @(negedge clk_48);
        check_eq("idle busy", busy[0], 0);

        burst(0, DEPTH, 8'($urandom));
        burst(1, 4, 8'h07);
        burst(2, 4, 8'h07);

        // CTS dropped mid-frame: current frame completes, queued word waits.
        wa = 8'($urandom);
        wb = 8'($urandom);
        write_word(0, wa);
        fork
            check_frame(0, wa, 4, "cts drop frame");
            begin
                repeat (12) @(negedge clk_48);
                cts[0] = 1'b0;
                write_word(0, wb);
            end
        join
        lows = 0;
        repeat (60) begin
            @(negedge clk_48);
            if (tx[0] !== 1'b1) lows++;
        end
        check_eq("cts drop idle", lows, 0);
        check_eq("cts drop level", level[0], 1);
        check_eq("cts drop busy", busy[0], 1);
        cts[0] = 1'b1;
        check_frame(0, wb, 10, "cts resume frame");

        // Reset mid-frame with words still queued.
        repeat (4) @(negedge clk_48);
        write_word(0, 8'h00);
        write_word(0, 8'($urandom));
        write_word(0, 8'($urandom));
        repeat (10) @(negedge clk_48);
        check_eq("pre-reset level", level[0], 2);
        rst_ = 1'b0;
        #1;
        check_eq("midreset tx", tx[0], 1);
        check_eq("midreset level", level[0], 0);
        check_eq("midreset busy", busy[0], 0);
        check_eq("midreset ready", wr_ready[0], 1);
        @(negedge clk_48);
        rst_ = 1'b1;
        lows = 0;
        repeat (10) begin
            @(negedge clk_48);
            if (tx[0] !== 1'b1) lows++;
        end
        check_eq("post-reset idle", lows, 0);
        check_eq("post-reset busy", busy[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
